// File: rtl/imem_loader_ctrl.sv
// Instruction-memory loader: assembles little-endian words from a byte stream,
// writes them into imem while holding the processor stopped, then releases it.
module imem_loader_ctrl #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] cpu_a,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic        cpu_run,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {RUN, COUNT, DATA, WRITE, DONE} state_t;

  localparam int PAD = 32 - DEPTH_LOG2 - 2;
  localparam logic [DEPTH_LOG2-1:0] ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [DEPTH_LOG2-1:0] n_last;    // N-1; count byte 0 yields all-ones (N = 2^DEPTH_LOG2)
  logic [1:0]            byte_idx;
  logic [3:0][7:0]       word;
  logic                  xfer;
  logic                  last;

  assign xfer   = in_valid && (state == COUNT || state == DATA);
  assign last   = (word_idx == n_last);
  assign mem_wd = word;
  assign mem_a  = (state == RUN) ? cpu_a : {{PAD{1'b0}}, word_idx, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_run   = 1'b0;
    busy      = 1'b1;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        cpu_run = 1'b1;
        busy    = 1'b0;
        if (load_req) state_nxt = COUNT;
      end
      COUNT: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (xfer && byte_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = last ? DONE : DATA;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_idx <= '0;
      byte_idx <= '0;
      n_last   <= '1;
      word     <= '0;
    end else begin
      case (state)
        COUNT: if (xfer) begin
          n_last   <= in_data[DEPTH_LOG2-1:0] - ONE;
          word_idx <= '0;
          byte_idx <= '0;
        end
        DATA: if (xfer) begin
          word[byte_idx] <= in_data;
          byte_idx       <= byte_idx + 2'd1;
        end
        // Final word leaves word_idx at N-1 so it never wraps back to 0.
        WRITE: if (!last) begin
          word_idx <= word_idx + ONE;
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl: reset, single/full/gapped loads,
// ignored requests and reset mid-load.
module tb_imem_loader_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] cpu_a = 32'h10;
  logic [31:0] mem_a, mem_wd;
  logic        mem_we, cpu_run, busy, done;

  int passed = 0;
  int total  = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int runlow = 0;
  int ndone  = 0;

  imem_loader_ctrl #(.DEPTH_LOG2(6)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .cpu_a(cpu_a), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_we(mem_we), .cpu_run(cpu_run), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory-side observer, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_a);
      wd.push_back(mem_wd);
    end
    if (!cpu_run) runlow++;
    if (done) ndone++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("handshake_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        tick();
      end
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    int base, r0, d0, bad;

    // Reset state
    repeat (3) tick();
    chk("rst_cpu_run", {31'd0, cpu_run}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_a", mem_a, 32'h10);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    reset = 1'b1;
    tick();
    cpu_a = 32'h24;
    #1;
    chk("run_mem_a_comb", mem_a, 32'h24);

    // in_valid in RUN is ignored
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    chk("run_valid_ready", {31'd0, in_ready}, 32'd0);
    chk("run_valid_cpu_run", {31'd0, cpu_run}, 32'd1);
    chk("run_valid_nowrite", wa.size(), 32'd0);
    in_valid = 1'b0;

    // Single-word load
    r0 = runlow;
    d0 = ndone;
    pulse_load();
    chk("sw_cpu_stop", {31'd0, cpu_run}, 32'd0);
    chk("sw_count_ready", {31'd0, in_ready}, 32'd1);
    chk("sw_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h0D);
    send_byte(8'hC0);
    send_byte(8'hA0);
    send_byte(8'hE3);
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_addr", mem_a, 32'h0);
    chk("sw_data", mem_wd, 32'hE3A0C00D);
    chk("sw_write_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("sw_done", {31'd0, done}, 32'd1);
    chk("sw_done_cpu", {31'd0, cpu_run}, 32'd0);
    tick();
    chk("sw_release", {31'd0, cpu_run}, 32'd1);
    repeat (2) tick();
    chk("sw_nwrites", wa.size(), 32'd1);
    chk("sw_log_data", wd[0], 32'hE3A0C00D);
    chk("sw_stop_cycles", runlow - r0, 32'd7);
    chk("sw_ndone", ndone - d0, 32'd1);

    // Full depth: count byte 0 means 64 words
    base = wa.size();
    d0 = ndone;
    pulse_load();
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) send_word(i, 1'b0);
    repeat (4) tick();
    chk("full_nwrites", wa.size() - base, 32'd64);
    bad = 0;
    for (int i = 0; i < 64 && base + i < wa.size(); i++)
      if (wa[base+i] !== 32'(4*i) || wd[base+i] !== 32'(i)) bad++;
    chk("full_bad_entries", bad, 32'd0);
    chk("full_last_addr", wa[wa.size()-1], 32'hFC);
    chk("full_ndone", ndone - d0, 32'd1);

    // Two-word load back-to-back, then the same with gapped valid
    base = wa.size();
    pulse_load();
    send_byte(8'h02);
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b0);
    repeat (4) tick();
    chk("b2b_nwrites", wa.size() - base, 32'd2);
    chk("b2b_w0", wd[base], 32'h11223344);
    chk("b2b_w1", wd[base+1], 32'h55667788);
    chk("b2b_a1", wa[base+1], 32'h4);
    base = wa.size();
    pulse_load();
    in_valid = 1'b0;
    tick();
    send_byte(8'h02);
    send_word(32'h11223344, 1'b1);
    send_word(32'h55667788, 1'b1);
    repeat (4) tick();
    chk("gap_nwrites", wa.size() - base, 32'd2);
    chk("gap_w0", wd[base], 32'h11223344);
    chk("gap_a0", wa[base], 32'h0);
    chk("gap_w1", wd[base+1], 32'h55667788);
    chk("gap_a1", wa[base+1], 32'h4);

    // load_req held high throughout a load
    base = wa.size();
    d0 = ndone;
    load_req = 1'b1;
    tick();
    send_byte(8'h01);
    send_word(32'h44332211, 1'b0);
    load_req = 1'b0;
    repeat (4) tick();
    chk("hold_nwrites", wa.size() - base, 32'd1);
    chk("hold_data", wd[base], 32'h44332211);
    chk("hold_ndone", ndone - d0, 32'd1);
    chk("hold_cpu_run", {31'd0, cpu_run}, 32'd1);

    // Reset mid-load
    base = wa.size();
    pulse_load();
    send_byte(8'h03);
    send_word(32'hAABBCCDD, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b0;
    #1;
    chk("mid_rst_cpu_run", {31'd0, cpu_run}, 32'd1);
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_nwrites", wa.size() - base, 32'd1);
    chk("mid_rst_w0", wd[base], 32'hAABBCCDD);
    base = wa.size();
    pulse_load();
    send_byte(8'h01);
    send_word(32'hCAFEF00D, 1'b0);
    repeat (4) tick();
    chk("reload_nwrites", wa.size() - base, 32'd1);
    chk("reload_addr", wa[wa.size()-1], 32'h0);
    chk("reload_data", wd[wd.size()-1], 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
